// File: rtl/ddr3_cmd_sequencer.sv
// rtl/ddr3_cmd_sequencer.sv - closed-page DDR3 init, refresh and ACT->RD/WR(AP) command sequencer
// Optional write ODT window enabled by defining DDR3_SEQ_ODT_EN.
module ddr3_cmd_sequencer #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 14,
  parameter int ROW_BITS  = 14,
  parameter int COL_BITS  = 10,
  parameter logic [ADDR_BITS-1:0] MR0_VAL = 14'h0120,
  parameter logic [ADDR_BITS-1:0] MR1_VAL = 14'h0004,
  parameter logic [ADDR_BITS-1:0] MR2_VAL = 14'h0000,
  parameter logic [ADDR_BITS-1:0] MR3_VAL = 14'h0000,
  parameter int T_RST     = 200,
  parameter int T_CKE     = 500,
  parameter int T_XPR     = 60,
  parameter int T_MRD     = 4,
  parameter int T_MOD     = 12,
  parameter int T_ZQINIT  = 512,
  parameter int T_RCD     = 5,
  parameter int T_RD_DONE = 16,
  parameter int T_WR_DONE = 22,
  parameter int T_RFC     = 88,
  parameter int T_REFI    = 3120,
  parameter int T_ODT     = 6
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BA_BITS-1:0]   req_bank,
  input  logic [ROW_BITS-1:0]  req_row,
  input  logic [COL_BITS-1:0]  req_col,
  output logic                 init_done,
  output logic                 mem_rst_n,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 ras_n,
  output logic                 cas_n,
  output logic                 we_n,
  output logic [BA_BITS-1:0]   ba,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 odt
);

  localparam int CW = 16;
  localparam logic [3:0] C_MRS = 4'b0000, C_REF = 4'b0001, C_ACT = 4'b0011, C_WR = 4'b0100;
  localparam logic [3:0] C_RD = 4'b0101, C_ZQCL = 4'b0110, C_NOP = 4'b0111, C_DESEL = 4'b1111;

  typedef enum logic [3:0] {
    S_RST_HOLD, S_CKE_WAIT, S_XPR_WAIT, S_MRS, S_MOD_WAIT, S_ZQ_WAIT,
    S_IDLE, S_RCD_WAIT, S_CAS_WAIT, S_REF_WAIT
  } state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d, wait_tgt, ref_cnt, ref_cnt_d;
  logic                 wait_done, ref_expire;
  logic [1:0]           mrs_idx, mrs_idx_d;
  logic [3:0]           cmd, cmd_d;
  logic                 mem_rst_n_d, cke_d, init_done_d, req_ready_d, ref_pending, ref_pending_d;
  logic [BA_BITS-1:0]   ba_d, lat_bank, lat_bank_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic [COL_BITS-1:0]  lat_col, lat_col_d;
  logic                 lat_write, lat_write_d;

  // Mode registers are loaded MR2, MR3, MR1, MR0.
  function automatic logic [BA_BITS+ADDR_BITS-1:0] mrs_entry(input logic [1:0] idx);
    case (idx)
      2'd0:    return {BA_BITS'(2), MR2_VAL};
      2'd1:    return {BA_BITS'(3), MR3_VAL};
      2'd2:    return {BA_BITS'(1), MR1_VAL};
      default: return {BA_BITS'(0), MR0_VAL};
    endcase
  endfunction

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state       <= S_RST_HOLD;
      cnt         <= '0;
      mrs_idx     <= '0;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      mem_rst_n   <= 1'b0;
      cke         <= 1'b0;
      cmd         <= C_DESEL;
      ba          <= '0;
      addr        <= '0;
      req_ready   <= 1'b0;
      init_done   <= 1'b0;
      lat_write   <= 1'b0;
      lat_bank    <= '0;
      lat_col     <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      mrs_idx     <= mrs_idx_d;
      ref_cnt     <= ref_cnt_d;
      ref_pending <= ref_pending_d;
      mem_rst_n   <= mem_rst_n_d;
      cke         <= cke_d;
      cmd         <= cmd_d;
      ba          <= ba_d;
      addr        <= addr_d;
      req_ready   <= req_ready_d;
      init_done   <= init_done_d;
      lat_write   <= lat_write_d;
      lat_bank    <= lat_bank_d;
      lat_col     <= lat_col_d;
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd;

  // A wait of T cycles fires when the in-state counter reaches T-1.
  always_comb begin
    case (state)
      S_RST_HOLD: wait_tgt = CW'(T_RST - 1);
      S_CKE_WAIT: wait_tgt = CW'(T_CKE - 1);
      S_XPR_WAIT: wait_tgt = CW'(T_XPR - 1);
      S_MRS:      wait_tgt = CW'(T_MRD - 1);
      S_MOD_WAIT: wait_tgt = CW'(T_MOD - 1);
      S_ZQ_WAIT:  wait_tgt = CW'(T_ZQINIT - 1);
      S_RCD_WAIT: wait_tgt = CW'(T_RCD - 1);
      S_CAS_WAIT: wait_tgt = lat_write ? CW'(T_WR_DONE - 1) : CW'(T_RD_DONE - 1);
      S_REF_WAIT: wait_tgt = CW'(T_RFC - 1);
      default:    wait_tgt = '0;
    endcase
    wait_done = (cnt == wait_tgt);
    state_d   = state;
    mrs_idx_d = mrs_idx;
    cnt_d     = wait_done ? '0 : cnt + CW'(1);
    case (state)
      S_RST_HOLD: if (wait_done) state_d = S_CKE_WAIT;
      S_CKE_WAIT: if (wait_done) state_d = S_XPR_WAIT;
      S_XPR_WAIT: if (wait_done) begin
        state_d   = S_MRS;
        mrs_idx_d = 2'd1;
      end
      S_MRS: if (wait_done) begin
        if (mrs_idx == 2'd3) state_d = S_MOD_WAIT;
        else                 mrs_idx_d = mrs_idx + 2'd1;
      end
      S_MOD_WAIT: if (wait_done) state_d = S_ZQ_WAIT;
      S_ZQ_WAIT:  if (wait_done) state_d = S_IDLE;
      S_IDLE: begin
        cnt_d = '0;
        if (ref_pending)                  state_d = S_REF_WAIT;
        else if (req_valid && req_ready)  state_d = S_RCD_WAIT;
      end
      S_RCD_WAIT: if (wait_done) state_d = S_CAS_WAIT;
      S_CAS_WAIT: if (wait_done) state_d = S_IDLE;
      S_REF_WAIT: if (wait_done) state_d = S_IDLE;
      default:    state_d = S_RST_HOLD;
    endcase
  end

`ifdef DDR3_SEQ_ODT_EN
  logic       odt_q, odt_d;
  logic [7:0] odt_cnt, odt_cnt_d;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      odt_q   <= 1'b0;
      odt_cnt <= '0;
    end else begin
      odt_q   <= odt_d;
      odt_cnt <= odt_cnt_d;
    end
  end

  assign odt = odt_q;
`else
  assign odt = 1'b0;
`endif

  always_comb begin
    mem_rst_n_d   = mem_rst_n;
    cke_d         = cke;
    init_done_d   = init_done;
    cmd_d         = cke ? C_NOP : C_DESEL;
    ba_d          = ba;
    addr_d        = addr;
    lat_write_d   = lat_write;
    lat_bank_d    = lat_bank;
    lat_col_d     = lat_col;
    ref_expire    = init_done && (ref_cnt == CW'(T_REFI - 1));
    ref_cnt_d     = (init_done && !ref_expire) ? ref_cnt + CW'(1) : '0;
    ref_pending_d = ref_pending;
    case (state)
      S_RST_HOLD: if (wait_done) mem_rst_n_d = 1'b1;
      S_CKE_WAIT: if (wait_done) begin
        cke_d = 1'b1;
        cmd_d = C_NOP;
      end
      S_XPR_WAIT, S_MRS: if (wait_done) begin
        cmd_d          = C_MRS;
        {ba_d, addr_d} = mrs_entry(mrs_idx);
      end
      S_MOD_WAIT: if (wait_done) begin
        cmd_d      = C_ZQCL;
        ba_d       = '0;
        addr_d     = '0;
        addr_d[10] = 1'b1;
      end
      S_ZQ_WAIT: if (wait_done) init_done_d = 1'b1;
      S_IDLE: begin
        if (ref_pending) begin
          cmd_d         = C_REF;
          ref_pending_d = 1'b0;
        end else if (req_valid && req_ready) begin
          cmd_d       = C_ACT;
          ba_d        = req_bank;
          addr_d      = ADDR_BITS'(req_row);
          lat_write_d = req_write;
          lat_bank_d  = req_bank;
          lat_col_d   = req_col;
        end
      end
      S_RCD_WAIT: if (wait_done) begin
        cmd_d                  = lat_write ? C_WR : C_RD;
        ba_d                   = lat_bank;
        addr_d                 = '0;
        addr_d[COL_BITS-1:0]   = lat_col;
        addr_d[10]             = 1'b1;
      end
      default: ;
    endcase
    // A fresh expiry wins over the clear so an interval is never dropped.
    if (ref_expire) ref_pending_d = 1'b1;
    req_ready_d = (state_d == S_IDLE) && !ref_pending_d && init_done_d;
`ifdef DDR3_SEQ_ODT_EN
    odt_d     = odt_q;
    odt_cnt_d = odt_cnt;
    if (odt_q) begin
      if (odt_cnt == 8'd0) odt_d = 1'b0;
      else                 odt_cnt_d = odt_cnt - 8'd1;
    end
    if (cmd_d == C_WR) begin
      odt_d     = 1'b1;
      odt_cnt_d = 8'(T_ODT - 1);
    end
`endif
  end

endmodule
